// File: rtl/iq_prog_delay_line.sv
// Programmable I/Q delay line: delays a gapped complex sample stream by 0..MAX_DELAY
// valid samples, zero-substituting until enough history has been captured.
module iq_prog_delay_line #(
   parameter int unsigned DW        = 18,
   parameter int unsigned MAX_DELAY = 32,
   parameter int unsigned DLW       = $clog2(MAX_DELAY + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DLW-1:0]       delay_in,
   input  logic                 delay_load,
   input  logic                 din_valid,
   input  logic signed [DW-1:0] dinI,
   input  logic signed [DW-1:0] dinQ,
   output logic signed [DW-1:0] doutI,
   output logic signed [DW-1:0] doutQ,
   output logic                 dout_valid,
   output logic [DLW-1:0]       delay_cur,
   output logic                 primed
);

   localparam int unsigned PW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
   localparam logic [DLW-1:0] MaxDly = DLW'(MAX_DELAY);
   localparam logic [DLW:0] MaxDlyX = (DLW + 1)'(MAX_DELAY);

   logic [2*DW-1:0]       mem_q [MAX_DELAY];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_idx;
   logic [DLW-1:0]        fill_q, fill_d;
   logic [DLW-1:0]        delay_q, delay_d;
   logic signed [DW-1:0]  i_q, q_q, i_d, q_d;
   logic                  valid_q;
   logic [DLW:0]          rd_sum;
   logic [2*DW-1:0]       rd_word;

   always_comb begin
      delay_d = (delay_in > MaxDly) ? MaxDly : delay_in;

      wr_ptr_d = (wr_ptr_q == PW'(MAX_DELAY - 1)) ? '0 : wr_ptr_q + PW'(1);
      fill_d   = (fill_q == MaxDly) ? fill_q : fill_q + DLW'(1);

      // Oldest-needed slot is wr_ptr - D modulo the buffer depth; D=MAX_DELAY reads
      // the slot about to be overwritten, which still holds the old sample.
      rd_sum  = (DLW + 1)'(wr_ptr_q) + MaxDlyX - {1'b0, delay_q};
      rd_idx  = (rd_sum >= MaxDlyX) ? PW'(rd_sum - MaxDlyX) : PW'(rd_sum);
      rd_word = mem_q[rd_idx];

      if (delay_q == '0) begin
         i_d = dinI;
         q_d = dinQ;
      end else if (fill_q >= delay_q) begin
         i_d = rd_word[2*DW-1:DW];
         q_d = rd_word[DW-1:0];
      end else begin
         i_d = '0;
         q_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         fill_q   <= '0;
         delay_q  <= '0;
         i_q      <= '0;
         q_q      <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= din_valid;
         if (delay_load) delay_q <= delay_d;
         if (din_valid) begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            i_q      <= i_d;
            q_q      <= q_d;
         end
      end
   end

   // Storage is deliberately not reset; the fill counter gates stale entries.
   always_ff @(posedge clk) begin
      if (!rst && din_valid) mem_q[wr_ptr_q] <= {dinI, dinQ};
   end

   assign doutI      = i_q;
   assign doutQ      = q_q;
   assign dout_valid = valid_q;
   assign delay_cur  = delay_q;
   assign primed     = (fill_q >= delay_q);

endmodule

// File: tb/tb_iq_prog_delay_line.sv
// Self-checking bench for iq_prog_delay_line: reference history model with a scoreboard
// queue, plus a hand-written vector table for the gapped-stream case.
module tb_iq_prog_delay_line;

   localparam int DW  = 18;
   localparam int MD  = 32;
   localparam int DLW = $clog2(MD + 1);

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [DLW-1:0]       delay_in = '0;
   logic                 delay_load = 1'b0;
   logic                 din_valid = 1'b0;
   logic signed [DW-1:0] dinI = '0;
   logic signed [DW-1:0] dinQ = '0;
   logic signed [DW-1:0] doutI, doutQ;
   logic                 dout_valid, primed;
   logic [DLW-1:0]       delay_cur;

   iq_prog_delay_line #(.DW(DW), .MAX_DELAY(MD)) dut (
      .clk        (clk),
      .rst        (rst),
      .delay_in   (delay_in),
      .delay_load (delay_load),
      .din_valid  (din_valid),
      .dinI       (dinI),
      .dinQ       (dinQ),
      .doutI      (doutI),
      .doutQ      (doutQ),
      .dout_valid (dout_valid),
      .delay_cur  (delay_cur),
      .primed     (primed)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {int i; int q;} samp_t;
   samp_t sb[$];
   int    hist_i[$];
   int    hist_q[$];
   int    mdelay = 0;
   int    last_i = 0;
   int    last_q = 0;

   typedef struct {
      bit v; int i; int q;
      bit ev; int ei; int eq;
   } vec_t;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus (called just after a falling edge) and check the result.
   task automatic step(input bit r, input bit ld, input int dly, input bit v,
                       input int i, input int q);
      samp_t e;
      int    n;
      rst = r; delay_load = ld; delay_in = DLW'(dly); din_valid = v;
      dinI = DW'(i); dinQ = DW'(q);
      #1;
      if (!r) begin
         check("delay_cur", delay_cur, mdelay);
         check("primed", primed, hist_i.size() >= mdelay);
      end
      if (r) begin
         hist_i.delete(); hist_q.delete(); sb.delete();
         mdelay = 0;
      end else begin
         if (v) begin
            n = hist_i.size();
            if (mdelay == 0) begin e.i = i; e.q = q; end
            else if (n >= mdelay) begin e.i = hist_i[n-mdelay]; e.q = hist_q[n-mdelay]; end
            else begin e.i = 0; e.q = 0; end
            sb.push_back(e);
            hist_i.push_back(i); hist_q.push_back(q);
         end
         if (ld) mdelay = (dly > MD) ? MD : dly;
      end
      @(posedge clk); #1;
      if (r) begin
         check("rst_valid", dout_valid, 0);
         check("rst_doutI", doutI, 0);
         check("rst_doutQ", doutQ, 0);
         last_i = 0; last_q = 0;
      end else if (v) begin
         check("dout_valid", dout_valid, 1);
         if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
         end else begin
            e = sb.pop_front();
            check("doutI", doutI, e.i);
            check("doutQ", doutQ, e.q);
            last_i = e.i; last_q = e.q;
         end
      end else begin
         check("gap_valid", dout_valid, 0);
         check("hold_doutI", doutI, last_i);
         check("hold_doutQ", doutQ, last_q);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      vec_t tbl[16];
      tbl = '{
         '{1, 1, -1, 1, 0, 0}, '{0, 0, 0, 0, 0, 0},
         '{1, 2, -2, 1, 0, 0}, '{0, 0, 0, 0, 0, 0},
         '{1, 3, -3, 1, 0, 0}, '{0, 0, 0, 0, 0, 0},
         '{1, 4, -4, 1, 1, -1}, '{0, 0, 0, 0, 1, -1},
         '{1, 5, -5, 1, 2, -2}, '{0, 0, 0, 0, 2, -2},
         '{1, 6, -6, 1, 3, -3}, '{0, 0, 0, 0, 3, -3},
         '{1, 7, -7, 1, 4, -4}, '{0, 0, 0, 0, 4, -4},
         '{1, 8, -8, 1, 5, -5}, '{0, 0, 0, 0, 5, -5}
      };

      @(negedge clk);
      // Reset state
      step(1, 0, 0, 0, 0, 0);
      check("reset_delay_cur", delay_cur, 0);
      check("reset_primed", primed, 1);

      // Bypass, D=0
      for (int n = 1; n <= 10; n++) step(0, 0, 0, 1, n, -n);
      idle();

      // Priming, D=5
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 5, 0, 0, 0);
      for (int n = 1; n <= 20; n++) step(0, 0, 0, 1, n, -n);

      // Gapped stream, D=3, from the vector table
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 3, 0, 0, 0);
      for (int k = 0; k < 16; k++) begin
         rst = 0; delay_load = 0; din_valid = tbl[k].v;
         dinI = DW'(tbl[k].i); dinQ = DW'(tbl[k].q);
         @(posedge clk); #1;
         check("tbl_valid", dout_valid, tbl[k].ev);
         check("tbl_doutI", doutI, tbl[k].ei);
         check("tbl_doutQ", doutQ, tbl[k].eq);
         @(negedge clk);
      end

      // Clamp and pointer wrap at maximum delay
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 40, 0, 0, 0);
      check("clamp_delay_cur", delay_cur, MD);
      for (int n = 1; n <= 100; n++) step(0, 0, 0, 1, n, -n);

      // Runtime delay change with retained history
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 8, 0, 0, 0);
      for (int n = 1; n <= 49; n++) step(0, 0, 0, 1, n, -n);
      step(0, 1, 2, 1, 50, -50);
      check("old_delay_out", doutI, 42);
      step(0, 0, 0, 1, 51, -51);
      check("new_delay_out", doutI, 49);
      for (int n = 52; n <= 60; n++) step(0, 0, 0, 1, n, -n);
      step(0, 1, 8, 0, 0, 0);
      step(0, 0, 0, 1, 61, -61);
      check("reload_history", doutI, 53);

      // Reset mid-stream with D=4
      step(0, 1, 4, 0, 0, 0);
      for (int n = 1; n <= 10; n++) step(0, 0, 0, 1, 100 + n, -n);
      step(1, 0, 0, 1, 555, -555);
      check("midrst_delay_cur", delay_cur, 0);
      step(0, 0, 0, 1, 777, -777);
      check("midrst_bypass", doutI, 777);

      // Sign extremes through D=1, with a gap
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 1, -131072, 131071);
      step(0, 0, 0, 1, 131071, -131072);
      idle();
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 7, 7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
